seg7_capture: RTL and testbench

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_capture_pkg.sv | 45 ++++
 rtl/seg7_capture_to_hex.sv | 22 ++
 rtl/seg7_capture.sv | 151 +++++++++++++++
 tb/tb_seg7_capture.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_capture_pkg.sv
// Shared definitions for the seven-segment display capture block:
// capture FSM states, glyph patterns and digit geometry.
package seg7_capture_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int NIBBLE_W   = 4;
  localparam int FRAME_W    = NUM_DIGITS * NIBBLE_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } capState_e;

  // Active-high segment patterns, bit order gfedcba
  localparam logic [6:0] GLYPH_0 = 7'b0111111;
  localparam logic [6:0] GLYPH_1 = 7'b0000110;
  localparam logic [6:0] GLYPH_2 = 7'b1011011;
  localparam logic [6:0] GLYPH_3 = 7'b1001111;
  localparam logic [6:0] GLYPH_4 = 7'b1100110;
  localparam logic [6:0] GLYPH_5 = 7'b1101101;
  localparam logic [6:0] GLYPH_6 = 7'b1111101;
  localparam logic [6:0] GLYPH_7 = 7'b0000111;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1101111;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b1111100;
  localparam logic [6:0] GLYPH_C = 7'b0111001;
  localparam logic [6:0] GLYPH_D = 7'b1011110;
  localparam logic [6:0] GLYPH_E = 7'b1111001;
  localparam logic [6:0] GLYPH_F = 7'b1110001;

  localparam logic [15:0][6:0] GLYPH_TABLE = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  function automatic logic [1:0] digitIndex(input logic [NUM_DIGITS-1:0] sel);
    digitIndex = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel[i]) digitIndex = 2'(i);
    end
  endfunction

endpackage

// File: rtl/seg7_capture_to_hex.sv
// Combinational glyph decoder: active-high segment pattern to hex nibble,
// flagging any pattern that is not one of the sixteen hex glyphs.
module seg7_to_hex
  import seg7_capture_pkg::*;
(
  input  logic [6:0]          pattern_i,
  output logic [NIBBLE_W-1:0] nibble_o,
  output logic                illegal_o
);

  always_comb begin
    nibble_o  = '0;
    illegal_o = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (pattern_i == GLYPH_TABLE[i]) begin
        nibble_o  = NIBBLE_W'(i);
        illegal_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Captures a 4-digit frame from a multiplexed seven-segment display by
// waiting for each digit's sample to stay stable, then hands frames off.
module seg7_capture
  import seg7_capture_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_n,
  input  logic [NUM_DIGITS-1:0] dig,
  output logic [FRAME_W-1:0]    value,
  output logic                  value_valid,
  input  logic                  value_ready,
  output logic                  bad_code,
  output logic                  overrun
);

  logic [6:0]            segSample_q, prevSeg_q;
  logic [NUM_DIGITS-1:0] digSample_q, prevDig_q;
  capState_e             state_q, state_d;
  logic [7:0]            count_q, count_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [FRAME_W-1:0]    digits_q, digits_d;
  logic [FRAME_W-1:0]    value_q, value_d;
  logic                  valid_q, valid_d;
  logic                  badCode_q, badCode_d;
  logic                  overrun_q, overrun_d;

  logic                  sampleOneHot;
  logic                  sampleSame;
  logic [7:0]            incCount;
  logic [1:0]            digitSel;
  logic [NIBBLE_W-1:0]   glyphNibble;
  logic                  glyphIllegal;
  logic                  stableHit;

  assign sampleOneHot = $onehot(digSample_q);
  assign sampleSame   = (segSample_q == prevSeg_q) && (digSample_q == prevDig_q);
  assign incCount     = count_q + 8'd1;
  assign digitSel     = digitIndex(digSample_q);

  seg7_to_hex u_decode (
    .pattern_i (~segSample_q),
    .nibble_o  (glyphNibble),
    .illegal_o (glyphIllegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      segSample_q <= '0;
      digSample_q <= '0;
      prevSeg_q   <= '0;
      prevDig_q   <= '0;
      state_q     <= IDLE;
      count_q     <= '0;
      mask_q      <= '0;
      digits_q    <= '0;
      value_q     <= '0;
      valid_q     <= 1'b0;
      badCode_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      segSample_q <= seg_n;
      digSample_q <= dig;
      prevSeg_q   <= segSample_q;
      prevDig_q   <= digSample_q;
      state_q     <= state_d;
      count_q     <= count_d;
      mask_q      <= mask_d;
      digits_q    <= digits_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      badCode_q   <= badCode_d;
      overrun_q   <= overrun_d;
    end
  end

  // Frame hand-off uses the registered mask, so a completed frame appears one edge after its last digit.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mask_d    = mask_q;
    digits_d  = digits_q;
    value_d   = value_q;
    valid_d   = valid_q;
    badCode_d = 1'b0;
    overrun_d = overrun_q;
    stableHit = 1'b0;

    if (valid_q && value_ready) valid_d = 1'b0;

    if (mask_q == '1) begin
      mask_d = '0;
      if (!valid_q || value_ready) begin
        value_d = digits_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (!sampleOneHot) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SETTLE;
          count_d = 8'd1;
        end
        SETTLE: begin
          if (sampleSame) begin
            count_d   = incCount;
            stableHit = (incCount == 8'(STABLE_CYCLES));
          end else begin
            count_d = 8'd1;
          end
        end
        HOLD: begin
          if (!sampleSame) begin
            state_d = SETTLE;
            count_d = 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end

    // An unreadable stable glyph poisons the whole frame in progress
    if (stableHit) begin
      state_d = HOLD;
      if (glyphIllegal) begin
        badCode_d = 1'b1;
        mask_d    = '0;
      end else begin
        digits_d[{digitSel, 2'b00} +: NIBBLE_W] = glyphNibble;
        mask_d[digitSel] = 1'b1;
      end
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign bad_code    = badCode_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scenarios plus randomized
// display traffic compared against a hold-level behavioural model.
module tb_seg7_capture;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_n;
  logic [3:0]  dig;
  logic [15:0] value;
  logic        value_valid;
  logic        value_ready;
  logic        bad_code;
  logic        overrun;

  always #5 clk = ~clk;

  seg7_capture #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .dig         (dig),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .bad_code    (bad_code),
    .overrun     (overrun)
  );

  int errors = 0;
  int checks = 0;

  // Lit segments (gfedcba) for hex digits 0..F
  logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    int         at;
    logic [6:0] segN;
    logic [3:0] sel;
  } cap_t;

  cap_t        capQ[$];
  int          edgeNum = 0;
  logic [3:0]  mDig [4];
  logic [3:0]  mMask;
  logic [15:0] mValue;
  logic        mValid, mBad, mOverrun;

  int          obsBad, expBad, obsRise, expRise;
  logic        prevObsValid = 1'b0, prevExpValid = 1'b0;
  logic [15:0] lastObsValue;

  function automatic int glyphIndex(input logic [6:0] lit);
    for (int i = 0; i < 16; i++) if (glyphs[i] == lit) return i;
    return -1;
  endfunction

  task automatic modelEdge();
    cap_t c;
    int   g;
    int   idx;
    mBad = 1'b0;
    if (rst) begin
      mMask = '0; mValue = '0; mValid = 1'b0; mOverrun = 1'b0;
      for (int i = 0; i < 4; i++) mDig[i] = '0;
      capQ.delete();
      return;
    end
    if (mMask == 4'hF) begin
      mMask = '0;
      if (!mValid || value_ready) begin
        mValue = {mDig[3], mDig[2], mDig[1], mDig[0]};
        mValid = 1'b1;
      end else begin
        mOverrun = 1'b1;
      end
    end else if (mValid && value_ready) begin
      mValid = 1'b0;
    end
    if (capQ.size() > 0 && capQ[0].at == edgeNum) begin
      c = capQ.pop_front();
      g = glyphIndex(~c.segN);
      idx = 0;
      for (int i = 0; i < 4; i++) if (c.sel[i]) idx = i;
      if (g < 0) begin
        mBad = 1'b1;
        mMask = '0;
      end else begin
        mDig[idx] = 4'(g);
        mMask[idx] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edgeNum++;
    modelEdge();
    #1;
    if (bad_code) obsBad++;
    if (mBad) expBad++;
    if (value_valid && !prevObsValid) obsRise++;
    if (mValid && !prevExpValid) expRise++;
    if (value_valid) lastObsValue = value;
    prevObsValid = value_valid;
    prevExpValid = mValid;
  endtask

  // A pattern held at the pins from edge t with a one-hot select is captured at edge t+S
  task automatic startHold(input logic [6:0] lit, input logic [3:0] sel, input int n);
    cap_t c;
    seg_n = ~lit;
    dig   = sel;
    if ($onehot(sel) && n >= S) begin
      c.at = edgeNum + 1 + S;
      c.segN = ~lit;
      c.sel = sel;
      capQ.push_back(c);
    end
  endtask

  task automatic driveHold(input logic [6:0] lit, input logic [3:0] sel, input int n);
    startHold(lit, sel, n);
    repeat (n) tick();
  endtask

  task automatic clearCounts();
    obsBad = 0; expBad = 0; obsRise = 0; expRise = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; seg_n = 7'h7F; dig = 4'b0000; value_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({value, value_valid, bad_code, overrun} !== 19'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h want 0", {value, value_valid, bad_code, overrun});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    clearCounts();
    value_ready = 1'b1;
    for (int d = 0; d < 4; d++) begin
      driveHold(glyphs[d + 1], 4'b0001 << d, 6);
      checks++;
      if ({value, value_valid, bad_code, overrun} !== {mValue, mValid, mBad, mOverrun}) begin
        errors++;
        $display("[TB] FAIL basic_digit%0d: got %h want %h", d,
                 {value, value_valid, bad_code, overrun}, {mValue, mValid, mBad, mOverrun});
      end
    end
    driveHold(7'h00, 4'b0000, 4);
    checks++;
    if (obsRise !== 1 || lastObsValue !== 16'h4321) begin
      errors++;
      $display("[TB] FAIL basic_frame: got rises=%0d value=%h want rises=1 value=4321", obsRise, lastObsValue);
    end
    checks++;
    if (obsBad !== 0 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_flags: got bad=%0d ovr=%b want 0 0", obsBad, overrun);
    end
  endtask

  task automatic test_latency();
    int t;
    value_ready = 1'b1;
    for (int d = 0; d < 3; d++) driveHold(glyphs[9 - d], 4'b0001 << d, 6);
    t = edgeNum + 1;
    startHold(glyphs[2], 4'b1000, S + 3);
    for (int k = 0; k < S + 3; k++) begin
      tick();
      checks++;
      if (value_valid !== (edgeNum == t + S + 1)) begin
        errors++;
        $display("[TB] FAIL latency_k%0d: got valid=%b want %b", k, value_valid, (edgeNum == t + S + 1));
      end
      checks++;
      if ({value, value_valid, bad_code, overrun} !== {mValue, mValid, mBad, mOverrun}) begin
        errors++;
        $display("[TB] FAIL latency_vec%0d: got %h want %h", k,
                 {value, value_valid, bad_code, overrun}, {mValue, mValid, mBad, mOverrun});
      end
    end
    driveHold(7'h00, 4'b0000, 3);
  endtask

  task automatic test_short_glitch();
    clearCounts();
    value_ready = 1'b1;
    driveHold(glyphs[7], 4'b0001, 3);
    driveHold(7'h00, 4'b0000, 3);
    for (int d = 1; d < 4; d++) driveHold(glyphs[5 + d], 4'b0001 << d, 6);
    driveHold(7'h00, 4'b0000, 3);
    checks++;
    if (obsRise !== 0) begin
      errors++;
      $display("[TB] FAIL glitch_no_capture: got rises=%0d want 0", obsRise);
    end
    driveHold(glyphs[5], 4'b0001, 6);
    driveHold(7'h00, 4'b0000, 3);
    checks++;
    if (obsRise !== 1 || lastObsValue !== 16'h8765 || expRise !== 1) begin
      errors++;
      $display("[TB] FAIL glitch_frame: got rises=%0d value=%h want rises=1 value=8765", obsRise, lastObsValue);
    end
  endtask

  task automatic test_bad_code();
    clearCounts();
    value_ready = 1'b1;
    driveHold(glyphs[9], 4'b0001, 6);
    driveHold(glyphs[10], 4'b0010, 6);
    driveHold(7'h00, 4'b0100, 6);
    driveHold(glyphs[11], 4'b0100, 6);
    driveHold(glyphs[12], 4'b1000, 6);
    driveHold(7'h00, 4'b0000, 3);
    checks++;
    if (obsBad !== 1 || obsRise !== 0) begin
      errors++;
      $display("[TB] FAIL bad_code_abort: got bad=%0d rises=%0d want bad=1 rises=0", obsBad, obsRise);
    end
    driveHold(glyphs[1], 4'b0001, 6);
    driveHold(glyphs[2], 4'b0010, 6);
    driveHold(7'h00, 4'b0000, 3);
    checks++;
    if (obsRise !== 1 || lastObsValue !== 16'hCB21 || expBad !== 1) begin
      errors++;
      $display("[TB] FAIL bad_code_refill: got rises=%0d value=%h want rises=1 value=CB21", obsRise, lastObsValue);
    end
  endtask

  task automatic test_overrun();
    rst = 1'b1; driveHold(7'h00, 4'b0000, 2); rst = 1'b0;
    value_ready = 1'b0;
    for (int d = 0; d < 4; d++) driveHold(glyphs[13 - d], 4'b0001 << d, 6);
    checks++;
    if ({value, value_valid, overrun} !== {16'hABCD, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL overrun_first: got %h want %h", {value, value_valid, overrun}, {16'hABCD, 1'b1, 1'b0});
    end
    driveHold(glyphs[1], 4'b0001, 6);
    driveHold(glyphs[0], 4'b0010, 6);
    driveHold(glyphs[15], 4'b0100, 6);
    driveHold(glyphs[14], 4'b1000, 6);
    driveHold(7'h00, 4'b0000, 3);
    checks++;
    if ({value, value_valid, overrun} !== {16'hABCD, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL overrun_drop: got %h want %h", {value, value_valid, overrun}, {16'hABCD, 1'b1, 1'b1});
    end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; driveHold(7'h00, 4'b0000, 2); rst = 1'b0;
    clearCounts();
    value_ready = 1'b0;
    for (int d = 0; d < 4; d++) driveHold(glyphs[8 - d], 4'b0001 << d, 6);
    for (int d = 0; d < 3; d++) driveHold(glyphs[4 - d], 4'b0001 << d, 6);
    startHold(glyphs[1], 4'b1000, S + 3);
    for (int k = 0; k < S + 3; k++) begin
      value_ready = (k == S + 1);
      tick();
      if (k == S) begin
        checks++;
        if ({value, value_valid} !== {16'h5678, 1'b1}) begin
          errors++;
          $display("[TB] FAIL b2b_pending: got %h want %h", {value, value_valid}, {16'h5678, 1'b1});
        end
      end
    end
    value_ready = 1'b0;
    driveHold(7'h00, 4'b0000, 2);
    checks++;
    if ({value, value_valid, overrun} !== {16'h1234, 1'b1, 1'b0} || obsRise !== 1) begin
      errors++;
      $display("[TB] FAIL b2b_swap: got %h rises=%0d want %h rises=1",
               {value, value_valid, overrun}, obsRise, {16'h1234, 1'b1, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; driveHold(7'h00, 4'b0000, 2); rst = 1'b0;
    value_ready = 1'b0;
    for (int d = 0; d < 4; d++) driveHold(glyphs[d + 1], 4'b0001 << d, 6);
    driveHold(glyphs[5], 4'b0001, 6);
    driveHold(glyphs[6], 4'b0010, 6);
    driveHold(glyphs[7], 4'b0100, 2);
    rst = 1'b1;
    driveHold(7'h00, 4'b0000, 1);
    rst = 1'b0;
    checks++;
    if ({value, value_valid, bad_code, overrun} !== 19'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_clear: got %h want 0", {value, value_valid, bad_code, overrun});
    end
    for (int d = 1; d < 4; d++) driveHold(glyphs[7 + d], 4'b0001 << d, 6);
    driveHold(7'h00, 4'b0000, 3);
    checks++;
    if (value_valid !== 1'b0 || bad_code !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_partial: got valid=%b bad=%b want 0 0", value_valid, bad_code);
    end
    driveHold(glyphs[11], 4'b0001, 6);
    driveHold(7'h00, 4'b0000, 2);
    checks++;
    if ({value, value_valid} !== {16'hA98B, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_mid_frame: got %h want %h", {value, value_valid}, {16'hA98B, 1'b1});
    end
    value_ready = 1'b1;
    driveHold(7'h00, 4'b0000, 2);
  endtask

  task automatic test_random();
    logic [6:0] lit, prevLit;
    logic [3:0] sel, prevSel;
    int         n;
    rst = 1'b1; driveHold(7'h00, 4'b0000, 2); rst = 1'b0;
    prevLit = 7'h00; prevSel = 4'b0000;
    for (int h = 0; h < 150; h++) begin
      if ($urandom_range(0, 9) < 8) lit = glyphs[$urandom_range(0, 15)];
      else lit = 7'($urandom);
      if ($urandom_range(0, 9) < 8) sel = 4'b0001 << $urandom_range(0, 3);
      else sel = 4'($urandom);
      if (lit == prevLit && sel == prevSel) lit = lit ^ 7'h08;
      n = $urandom_range(1, S + 3);
      startHold(lit, sel, n);
      for (int k = 0; k < n; k++) begin
        value_ready = 1'($urandom_range(0, 1));
        tick();
        checks++;
        if ({value, value_valid, bad_code, overrun} !== {mValue, mValid, mBad, mOverrun}) begin
          errors++;
          $display("[TB] FAIL random_h%0d_k%0d: got %h want %h", h, k,
                   {value, value_valid, bad_code, overrun}, {mValue, mValid, mBad, mOverrun});
        end
      end
      prevLit = lit; prevSel = sel;
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_latency();
    test_short_glitch();
    test_bad_code();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
